// File: rtl/regfile_unique0.sv
// Two-read / one-write integer register file with a hard-wired zero register.
// Reads are combinational and write-first: a same-cycle write to the addressed
// register is forwarded to the read data. Reset clears every register and
// suppresses that forwarding for the cycle in which it is asserted.
module regfile_unique0 #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rdata2,
  input  logic [4:0]      wreg,
  input  logic [XLEN-1:0] wdata,
  input  logic            wen
);

  localparam int AW = 5;
  localparam int NPORTS = 2;

  // Entry 0 is never written, so it stays at the value reset gave it.
  // Reads still force x0 to zero, so its contents before the first reset do not matter.
  logic [XLEN-1:0] r_regs [NREG];

  // A write that really lands this edge: enabled, not to x0, and not overridden by reset.
  logic w_wr_active;
  assign w_wr_active = wen && (wreg != '0) && !reset;

  // Register update: reset clears everything and wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wen && (wreg != '0)) begin
      r_regs[wreg] <= wdata;
    end
  end

  // Read-port addresses gathered so both ports share one generated read path.
  logic [AW-1:0] w_rs [NPORTS];
  assign w_rs[0] = rs1;
  assign w_rs[1] = rs2;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_rd
      logic [XLEN-1:0] w_rd;

      // Combinational read: x0 is zero, a matching live write is forwarded, else the stored value.
      always_comb begin
        w_rd = r_regs[w_rs[gi]];
        if (w_rs[gi] == '0) begin
          w_rd = '0;
        end else if (w_wr_active && (wreg == w_rs[gi])) begin
          w_rd = wdata;
        end
      end
    end
  endgenerate

  assign rdata1 = g_rd[0].w_rd;
  assign rdata2 = g_rd[1].w_rd;

endmodule

// File: tb/tb_regfile_unique0.sv
// Self-checking bench for regfile_unique0: directed scenarios followed by
// randomized traffic, with both read ports compared every cycle against an
// array model of the architectural registers.
module tb_regfile_unique0;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1;
  logic [31:0] rdata1;
  logic [4:0]  rs2;
  logic [31:0] rdata2;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        wen;

  int n_cmp;
  int n_fail;

  // Architectural register contents as software sees them.
  logic [31:0] model [32];

  regfile_unique0 #(.XLEN(32), .NREG(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .rs1    (rs1),
    .rdata1 (rdata1),
    .rs2    (rs2),
    .rdata2 (rdata2),
    .wreg   (wreg),
    .wdata  (wdata),
    .wen    (wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read of register idx must return in the current cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic rst,
                                           input logic we, input logic [4:0] wr,
                                           input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (!rst && we && (wr == idx)) return wd;
    return model[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check both combinational reads, then clock and update the model.
  task automatic step(input string tag, input logic rst, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] a, input logic [4:0] b);
    logic [31:0] e1;
    logic [31:0] e2;
    reset = rst; wen = we; wreg = wr; wdata = wd; rs1 = a; rs2 = b;
    #2;
    e1 = ref_read(a, rst, we, wr, wd);
    e2 = ref_read(b, rst, we, wr, wd);
    $display("step %s rst=%0b wen=%0b wreg=%0d wdata=%h rs1=%0d rd1=%h rs2=%0d rd2=%h",
             tag, rst, we, wr, wd, a, rdata1, b, rdata2);
    chk({tag, ".rdata1"}, rdata1, e1);
    chk({tag, ".rdata2"}, rdata2, e2);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && (wr != 5'd0)) begin
      model[wr] = wd;
    end
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1; wen = 1'b0; wreg = 5'd0; wdata = 32'h0; rs1 = 5'd0; rs2 = 5'd0;

    // Initial reset: stored contents are unknown before this edge, so nothing is checked yet.
    @(posedge clk);
    #1;

    // Every register reads zero after reset, on both ports.
    for (int i = 0; i < 32; i++) begin
      step("reset_read", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    end

    // Write then read back on both ports.
    step("wr_x5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    step("rd_x5", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Writes to x0 are dropped and never forwarded.
    step("wr_x0", 1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    step("rd_x0", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);

    // Write-first bypass on one port while the other reads a different register.
    step("wr_x8", 1'b0, 1'b1, 5'd8, 32'h88888888, 5'd0, 5'd0);
    step("wr_x7", 1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    step("byp_x7", 1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd8);
    step("byp_both", 1'b0, 1'b1, 5'd9, 32'h99999999, 5'd9, 5'd9);
    step("rd_x7x9", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd9);

    // Highest register holds its value across idle cycles with wdata changing.
    step("wr_x31", 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step("hold_x31", 1'b0, 1'b0, 5'd31, 32'h0, 5'd31, 5'd31);
    end

    // Reset beats a simultaneous write and suppresses the bypass in that cycle.
    step("wr_x10", 1'b0, 1'b1, 5'd10, 32'hA5A5A5A5, 5'd0, 5'd0);
    step("rst_wr_x10", 1'b1, 1'b1, 5'd10, 32'h5A5A5A5A, 5'd10, 5'd31);
    step("rd_x10", 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd31);

    // Randomized traffic with frequent address collisions and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic        r_rst;
      logic        r_we;
      logic [4:0]  r_wr;
      logic [31:0] r_wd;
      logic [4:0]  r_a;
      logic [4:0]  r_b;
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = ($urandom_range(0, 2) != 0);
      r_wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_a   = ($urandom_range(0, 2) == 0) ? r_wr : 5'($urandom_range(0, 31));
      r_b   = ($urandom_range(0, 2) == 0) ? r_wr : 5'($urandom_range(0, 31));
      step("rand", r_rst, r_we, r_wr, r_wd, r_a, r_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
